move_scheduler: RTL

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/move_pkg.sv | 38 +++
 rtl/move_step.sv | 42 ++++
 rtl/move_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/move_pkg.sv
// Shared definitions for the sprite move scheduler: direction codes, playfield
// bounds, reset positions and the scheduler state encoding.
package move_pkg;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_LEFT  = 3'd2;
    localparam logic [2:0] DIR_RIGHT = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    localparam int X_MIN_DEF       = 62;
    localparam int X_MAX_DEF       = 902;
    localparam int Y_MIN_DEF       = 108;
    localparam int Y_MAX_DEF       = 648;
    localparam int CHK_TIMEOUT_DEF = 255;

    // Hero starts mid-field; enemies start in the top corners (set from bounds)
    localparam logic [11:0] HERO_X_RST = 12'd512;
    localparam logic [11:0] HERO_Y_RST = 12'd300;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PROPOSE = 3'd1,
        ST_CHECK   = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_NEXT    = 3'd4
    } state_t;

    // Codes 5-7 are reserved and behave like NONE
    function automatic logic dir_moves(input logic [2:0] d);
        return (d >= DIR_UP) && (d <= DIR_DOWN);
    endfunction

    function automatic logic [1:0] slot_inc(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

endpackage

// File: rtl/move_step.sv
// Combinational one-pixel step of a sprite position with an inclusive bounds test.
// The 13-bit intermediate keeps 0-1 and 4095+1 from wrapping back into range.
module move_step
    import move_pkg::*;
#(
    parameter int X_MIN = X_MIN_DEF,
    parameter int X_MAX = X_MAX_DEF,
    parameter int Y_MIN = Y_MIN_DEF,
    parameter int Y_MAX = Y_MAX_DEF
) (
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic [2:0]  dir,
    output logic [11:0] cand_x,
    output logic [11:0] cand_y,
    output logic        in_bounds
);

    logic [12:0] wide_x_s;
    logic [12:0] wide_y_s;

    // Candidate position and bounds test
    always_comb begin
        wide_x_s = {1'b0, x};
        wide_y_s = {1'b0, y};
        case (dir)
            DIR_UP:    wide_y_s = {1'b0, y} - 13'd1;
            DIR_LEFT:  wide_x_s = {1'b0, x} - 13'd1;
            DIR_RIGHT: wide_x_s = {1'b0, x} + 13'd1;
            DIR_DOWN:  wide_y_s = {1'b0, y} + 13'd1;
            default: begin
                wide_x_s = {1'b0, x};
                wide_y_s = {1'b0, y};
            end
        endcase
        in_bounds = (wide_x_s >= 13'(X_MIN)) && (wide_x_s <= 13'(X_MAX)) &&
                    (wide_y_s >= 13'(Y_MIN)) && (wide_y_s <= 13'(Y_MAX));
        cand_x = wide_x_s[11:0];
        cand_y = wide_y_s[11:0];
    end

endmodule

// File: rtl/move_scheduler.sv
// Per-frame round-robin mover for three sprites; each legal move is validated by
// a shared collision checker before it is committed. Start slot rotates per round.
module move_scheduler
    import move_pkg::*;
#(
    parameter int X_MIN       = X_MIN_DEF,
    parameter int X_MAX       = X_MAX_DEF,
    parameter int Y_MIN       = Y_MIN_DEF,
    parameter int Y_MAX       = Y_MAX_DEF,
    parameter int CHK_TIMEOUT = CHK_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [2:0]  dir0,
    input  logic [2:0]  dir1,
    input  logic [2:0]  dir2,
    output logic        chk_valid,
    output logic [1:0]  chk_id,
    output logic [11:0] chk_x,
    output logic [11:0] chk_y,
    input  logic        chk_done,
    input  logic        chk_hit,
    output logic [11:0] x0,
    output logic [11:0] y0,
    output logic [11:0] x1,
    output logic [11:0] y1,
    output logic [11:0] x2,
    output logic [11:0] y2,
    output logic        round_done,
    output logic        overrun,
    output logic        chk_err
);

    localparam logic [15:0] TMO_LAST = 16'(CHK_TIMEOUT - 1);

    state_t      state_r;
    logic [1:0]  slot_r;
    logic [1:0]  start_r;
    logic [1:0]  cnt_r;
    logic [15:0] tmo_r;
    logic [2:0]  dir_r   [0:2];
    logic [11:0] pos_x_r [0:2];
    logic [11:0] pos_y_r [0:2];
    logic [11:0] cand_x_s;
    logic [11:0] cand_y_s;
    logic        in_bounds_s;

    move_step #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
    ) u_step (
        .x        (pos_x_r[slot_r]),
        .y        (pos_y_r[slot_r]),
        .dir      (dir_r[slot_r]),
        .cand_x   (cand_x_s),
        .cand_y   (cand_y_s),
        .in_bounds(in_bounds_s)
    );

    assign x0 = pos_x_r[0];
    assign y0 = pos_y_r[0];
    assign x1 = pos_x_r[1];
    assign y1 = pos_y_r[1];
    assign x2 = pos_x_r[2];
    assign y2 = pos_y_r[2];

    // Scheduler FSM with registered checker request, positions and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            slot_r     <= 2'd0;
            start_r    <= 2'd0;
            cnt_r      <= 2'd0;
            tmo_r      <= 16'd0;
            chk_valid  <= 1'b0;
            chk_id     <= 2'd0;
            chk_x      <= 12'd0;
            chk_y      <= 12'd0;
            round_done <= 1'b0;
            overrun    <= 1'b0;
            chk_err    <= 1'b0;
            dir_r[0]   <= DIR_NONE;
            dir_r[1]   <= DIR_NONE;
            dir_r[2]   <= DIR_NONE;
            pos_x_r[0] <= HERO_X_RST;
            pos_y_r[0] <= HERO_Y_RST;
            pos_x_r[1] <= 12'(X_MIN);
            pos_y_r[1] <= 12'(Y_MIN);
            pos_x_r[2] <= 12'(X_MAX);
            pos_y_r[2] <= 12'(Y_MIN);
        end else begin
            round_done <= 1'b0;
            if (frame_tick && (state_r != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (frame_tick) begin
                        dir_r[0] <= dir0;
                        dir_r[1] <= dir1;
                        dir_r[2] <= dir2;
                        slot_r   <= start_r;
                        cnt_r    <= 2'd0;
                        state_r  <= ST_PROPOSE;
                    end
                end
                ST_PROPOSE: begin
                    if (dir_moves(dir_r[slot_r]) && in_bounds_s) begin
                        chk_valid <= 1'b1;
                        chk_id    <= slot_r;
                        chk_x     <= cand_x_s;
                        chk_y     <= cand_y_s;
                        tmo_r     <= 16'd0;
                        state_r   <= ST_CHECK;
                    end else begin
                        state_r <= ST_NEXT;
                    end
                end
                ST_CHECK: begin
                    // A silent checker is treated as a hit so the round still ends
                    if (chk_done) begin
                        chk_valid <= 1'b0;
                        state_r   <= chk_hit ? ST_NEXT : ST_COMMIT;
                    end else if (tmo_r == TMO_LAST) begin
                        chk_valid <= 1'b0;
                        chk_err   <= 1'b1;
                        state_r   <= ST_NEXT;
                    end else begin
                        tmo_r <= tmo_r + 16'd1;
                    end
                end
                ST_COMMIT: begin
                    pos_x_r[chk_id] <= chk_x;
                    pos_y_r[chk_id] <= chk_y;
                    state_r         <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (cnt_r == 2'd2) begin
                        round_done <= 1'b1;
                        start_r    <= slot_inc(start_r);
                        state_r    <= ST_IDLE;
                    end else begin
                        cnt_r   <= cnt_r + 2'd1;
                        slot_r  <= slot_inc(slot_r);
                        state_r <= ST_PROPOSE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
